// File: rtl/rng_share_ctrl.sv
// rng_share_ctrl
//
// Sequencing controller and round-robin arbiter for one shared LFSR random
// generator. The block owns the generator's reset and seed inputs. It holds the
// generator in reset, seeds it and discards a warm-up run. After that it hands
// out one random word per cycle to N_REQ requesters.
//
// Ports
//   clk, reset    clock, asynchronous active-high reset
//   cfg_seed_i    seed, sampled only on a cfg_start_i cycle
//   cfg_start_i   single-cycle pulse: (re)seed and start
//   cfg_err_o     single-cycle pulse: start rejected because the seed was zero
//   ready_o       high while in RUN
//   rng_reset_o   generator reset
//   rng_seed_o    generator seed
//   rng_val_i     generator output
//   req_i         per-requester request level, held until granted
//   gnt_o         registered one-hot grant pulse
//   rsp_valid_o   high in the same cycle as gnt_o
//   rsp_data_o    random word for the granted requester
//   rsp_id_o      index of the granted requester
//   draw_cnt_o    grants since the last seeding, wraps at 16 bits
`timescale 1ns/1ps

module rng_share_ctrl #(
    parameter int unsigned N_REQ  = 4,
    parameter int unsigned WARMUP = 16,
    parameter int unsigned SEED_W = 11,
    parameter int unsigned RAND_W = 33
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [SEED_W-1:0]        cfg_seed_i,
    input  logic                     cfg_start_i,
    output logic                     cfg_err_o,
    output logic                     ready_o,
    output logic                     rng_reset_o,
    output logic [SEED_W-1:0]        rng_seed_o,
    input  logic [RAND_W-1:0]        rng_val_i,
    input  logic [N_REQ-1:0]         req_i,
    output logic [N_REQ-1:0]         gnt_o,
    output logic                     rsp_valid_o,
    output logic [RAND_W-1:0]        rsp_data_o,
    output logic [$clog2(N_REQ)-1:0] rsp_id_o,
    output logic [15:0]              draw_cnt_o
);

    localparam int unsigned IdW = $clog2(N_REQ);

    typedef enum logic [1:0] {
        StIdle,
        StSeed,
        StWarm,
        StRun
    } state_e;

    state_e              state_q, state_d;
    logic [SEED_W-1:0]   seed_q, seed_d;
    logic                pend_q, pend_d;   // reseed requested: leave IDLE on its own
    logic [7:0]          warm_q, warm_d;
    logic [IdW-1:0]      ptr_q, ptr_d;
    logic [N_REQ-1:0]    gnt_q, gnt_d;
    logic                valid_q, valid_d;
    logic [RAND_W-1:0]   data_q, data_d;
    logic [IdW-1:0]      id_q, id_d;
    logic [15:0]         draw_q, draw_d;
    logic                err_q, err_d;

    logic                seed_ok;
    logic                seed_bad;
    logic                reseed;
    logic [N_REQ-1:0]    req_v;
    logic                win_found;
    logic [IdW-1:0]      win_idx;
    logic                grant_en;

    assign seed_ok  = cfg_start_i && (cfg_seed_i != '0);
    assign seed_bad = cfg_start_i && (cfg_seed_i == '0);
    assign reseed   = seed_ok && (state_q != StIdle);

    // Only a definite 1 counts as a request; X/Z falls through to 0.
    always_comb begin
        req_v = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (req_i[i]) begin
                req_v[i] = 1'b1;
            end
        end
    end

    // Round-robin search starting at the pointer and wrapping at N_REQ-1.
    always_comb begin
        int unsigned    idx;
        logic [IdW-1:0] idx_w;
        win_found = 1'b0;
        win_idx   = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            idx = 32'(ptr_q) + k;
            if (idx >= N_REQ) begin
                idx = idx - N_REQ;
            end
            idx_w = idx[IdW-1:0];
            if (!win_found && req_v[idx_w]) begin
                win_found = 1'b1;
                win_idx   = idx_w;
            end
        end
    end

    // A reseed in the same cycle drops the request.
    assign grant_en = (state_q == StRun) && win_found && !seed_ok;

    // Sequencing FSM.
    always_comb begin
        state_d = state_q;
        seed_d  = seed_q;
        pend_d  = pend_q;
        warm_d  = warm_q;
        unique case (state_q)
            StIdle: begin
                if (seed_ok) begin
                    seed_d  = cfg_seed_i;
                    pend_d  = 1'b0;
                    state_d = StSeed;
                end else if (pend_q) begin
                    pend_d  = 1'b0;
                    state_d = StSeed;
                end
            end
            StSeed: begin
                warm_d  = '0;
                state_d = StWarm;
            end
            StWarm: begin
                if (warm_q == 8'(WARMUP - 1)) begin
                    state_d = StRun;
                end else begin
                    warm_d = warm_q + 8'd1;
                end
            end
            StRun: begin
                state_d = StRun;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
        // Reseed from any active state: spend one cycle in IDLE so that the
        // generator reset clears its load flag, then go to SEED.
        if (reseed) begin
            seed_d  = cfg_seed_i;
            pend_d  = 1'b1;
            state_d = StIdle;
        end
    end

    // Grant and response next-state.
    always_comb begin
        gnt_d   = '0;
        valid_d = 1'b0;
        id_d    = id_q;
        data_d  = data_q;
        ptr_d   = ptr_q;
        draw_d  = draw_q;
        err_d   = seed_bad;
        if (grant_en) begin
            gnt_d[win_idx] = 1'b1;
            valid_d        = 1'b1;
            id_d           = win_idx;
            data_d         = rng_val_i;
            draw_d         = draw_q + 16'd1;
            if (win_idx == IdW'(N_REQ - 1)) begin
                ptr_d = '0;
            end else begin
                ptr_d = win_idx + IdW'(1);
            end
        end
        if (reseed || (state_q == StIdle)) begin
            ptr_d  = '0;
            draw_d = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            seed_q  <= '0;
            pend_q  <= 1'b0;
            warm_q  <= '0;
            ptr_q   <= '0;
            gnt_q   <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
            id_q    <= '0;
            draw_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            seed_q  <= seed_d;
            pend_q  <= pend_d;
            warm_q  <= warm_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            id_q    <= id_d;
            draw_q  <= draw_d;
            err_q   <= err_d;
        end
    end

    assign ready_o     = (state_q == StRun);
    assign rng_reset_o = (state_q == StIdle);
    assign rng_seed_o  = seed_q;
    assign cfg_err_o   = err_q;
    assign gnt_o       = gnt_q;
    assign rsp_valid_o = valid_q;
    assign rsp_data_o  = data_q;
    assign rsp_id_o    = id_q;
    assign draw_cnt_o  = draw_q;

endmodule

// File: tb/tb_rng_share_ctrl.sv
// Directed bench for rng_share_ctrl with a behavioural stand-in for the
// shared 33-bit LFSR generator. The stand-in has three 11-bit lanes. It loads
// its seed on the first cycle after reset in which the seed is nonzero, and it
// shifts on every cycle after that.
`timescale 1ns/1ps

module tb_rng_share_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [10:0] cfg_seed;
    logic        cfg_start;
    logic        cfg_err;
    logic        ready;
    logic        rng_reset;
    logic [10:0] rng_seed;
    logic [32:0] rng_val;
    logic [3:0]  req;
    logic [3:0]  gnt;
    logic        rsp_valid;
    logic [32:0] rsp_data;
    logic [1:0]  rsp_id;
    logic [15:0] draw_cnt;

    int checks = 0;
    int errors = 0;

    logic [32:0] last_val;
    logic [32:0] prev_data;
    logic [32:0] words [3];
    logic        bad;
    int          n;

    rng_share_ctrl #(
        .N_REQ (4),
        .WARMUP(16),
        .SEED_W(11),
        .RAND_W(33)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .cfg_seed_i (cfg_seed),
        .cfg_start_i(cfg_start),
        .cfg_err_o  (cfg_err),
        .ready_o    (ready),
        .rng_reset_o(rng_reset),
        .rng_seed_o (rng_seed),
        .rng_val_i  (rng_val),
        .req_i      (req),
        .gnt_o      (gnt),
        .rsp_valid_o(rsp_valid),
        .rsp_data_o (rsp_data),
        .rsp_id_o   (rsp_id),
        .draw_cnt_o (draw_cnt)
    );

    always #5 clk = ~clk;

    // Generator stand-in.
    logic [32:0] gen_q      = '0;
    logic        gen_loaded = 1'b0;

    function automatic logic [10:0] lane_step(input logic [10:0] l);
        return {l[9:0], l[10] ^ l[8]};
    endfunction

    always @(posedge clk) begin
        if (rng_reset) begin
            gen_loaded <= 1'b0;
            gen_q      <= '0;
        end else if (!gen_loaded) begin
            if (rng_seed != 11'd0) begin
                gen_q      <= {rng_seed, {rng_seed[0], rng_seed[10:1]},
                               {rng_seed[4:0], rng_seed[10:5]}};
                gen_loaded <= 1'b1;
            end
        end else begin
            gen_q <= {lane_step(gen_q[32:22]), lane_step(gen_q[21:11]),
                      lane_step(gen_q[10:0])};
        end
    end

    assign rng_val = gen_q;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Remember the generator word presented to this edge, then step one cycle
    // and settle 1 ns past the edge.
    task automatic tick();
        last_val = rng_val;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset     = 1'b1;
        cfg_seed  = '0;
        cfg_start = 1'b0;
        req       = '0;
        #12;
        check("rst_rng_reset", 64'(rng_reset), 64'(1));
        check("rst_rng_seed", 64'(rng_seed), 64'(0));
        check("rst_gnt", 64'(gnt), 64'(0));
        check("rst_valid", 64'(rsp_valid), 64'(0));
        check("rst_data", 64'(rsp_data), 64'(0));
        check("rst_id", 64'(rsp_id), 64'(0));
        check("rst_draw", 64'(draw_cnt), 64'(0));
        check("rst_ready", 64'(ready), 64'(0));
        check("rst_err", 64'(cfg_err), 64'(0));
        @(negedge clk);
        reset = 1'b0;
        tick();

        // Zero seed is rejected in IDLE.
        cfg_start = 1'b1;
        cfg_seed  = 11'h000;
        tick();
        cfg_start = 1'b0;
        check("zero_err", 64'(cfg_err), 64'(1));
        check("zero_ready", 64'(ready), 64'(0));
        check("zero_rng_reset", 64'(rng_reset), 64'(1));
        tick();
        check("zero_err_pulse", 64'(cfg_err), 64'(0));
        check("zero_rng_reset2", 64'(rng_reset), 64'(1));

        // Start with 2A5. Requests are already held during warm-up.
        req       = 4'b0110;
        cfg_seed  = 11'h2A5;
        cfg_start = 1'b1;
        tick();                                   // edge 1: SEED
        cfg_start = 1'b0;
        cfg_seed  = '0;
        check("seed_rng_reset", 64'(rng_reset), 64'(0));
        check("seed_rng_seed", 64'(rng_seed), 64'(11'h2A5));
        check("seed_ready", 64'(ready), 64'(0));
        bad = 1'b0;
        for (int e = 2; e <= 17; e++) begin
            tick();
            if (ready || (gnt != 4'b0000) || rng_reset || (rng_seed != 11'h2A5)) bad = 1'b1;
        end
        check("warm_quiet", 64'(bad), 64'(0));
        tick();                                   // edge 18: RUN
        check("ready_at_18", 64'(ready), 64'(1));
        check("no_gnt_at_18", 64'(gnt), 64'(0));
        tick();                                   // edge 19: first grant
        check("warm_req_gnt", 64'(gnt), 64'(4'b0010));
        check("warm_req_valid", 64'(rsp_valid), 64'(1));
        check("warm_req_id", 64'(rsp_id), 64'(1));
        check("warm_req_data", 64'(rsp_data), 64'(last_val));
        check("warm_req_draw", 64'(draw_cnt), 64'(1));

        req = 4'b0000;
        tick();
        check("idle_gnt", 64'(gnt), 64'(0));
        check("idle_valid", 64'(rsp_valid), 64'(0));

        // The pointer is now 2.
        req = 4'b0011;
        tick();
        check("ptr2_gnt0", 64'(gnt), 64'(4'b0001));
        check("ptr2_data0", 64'(rsp_data), 64'(last_val));
        req = 4'b0010;
        tick();
        check("ptr2_gnt1", 64'(gnt), 64'(4'b0010));
        req = 4'b1000;
        tick();
        check("lone3_gnt", 64'(gnt), 64'(4'b1000));
        check("lone3_id", 64'(rsp_id), 64'(3));
        req = 4'b0000;
        tick();
        check("lone3_after", 64'(gnt), 64'(0));
        check("draw_4", 64'(draw_cnt), 64'(4));

        // All four held: strict rotation and distinct words.
        prev_data = rsp_data;
        req = 4'b1111;
        for (int i = 0; i < 8; i++) begin
            tick();
            check("rot_gnt", 64'(gnt), 64'(4'b0001 << (i % 4)));
            check("rot_data", 64'(rsp_data), 64'(last_val));
            check("rot_distinct", 64'(rsp_data != prev_data), 64'(1));
            prev_data = rsp_data;
        end
        req = 4'b0000;
        tick();
        check("rot_after", 64'(gnt), 64'(0));
        check("draw_12", 64'(draw_cnt), 64'(12));

        // Zero seed in RUN gives an error pulse and keeps running.
        cfg_start = 1'b1;
        cfg_seed  = 11'h000;
        tick();
        cfg_start = 1'b0;
        check("run_zero_err", 64'(cfg_err), 64'(1));
        check("run_zero_ready", 64'(ready), 64'(1));

        // Reseed twice with 001 and expect an identical word stream.
        for (int run = 0; run < 2; run++) begin
            req       = 4'b0101;
            cfg_seed  = 11'h001;
            cfg_start = 1'b1;
            tick();                               // edge 1: IDLE
            cfg_start = 1'b0;
            cfg_seed  = '0;
            check("rs_gnt", 64'(gnt), 64'(0));
            check("rs_ready", 64'(ready), 64'(0));
            check("rs_rng_reset", 64'(rng_reset), 64'(1));
            check("rs_draw", 64'(draw_cnt), 64'(0));
            n = 1;
            while ((gnt == 4'b0000) && (n < 40)) begin
                tick();
                n++;
            end
            check("rs_first_gnt_edge", 64'(n), 64'(20));
            check("rs_first_gnt", 64'(gnt), 64'(4'b0001));
            check("rs_first_id", 64'(rsp_id), 64'(0));
            check("rs_first_draw", 64'(draw_cnt), 64'(1));
            check("rs_first_data", 64'(rsp_data), 64'(last_val));
            if (run == 0) words[0] = last_val;
            else check("replay0", 64'(rsp_data), 64'(words[0]));
            req = 4'b0100;
            tick();
            check("rs_gnt2", 64'(gnt), 64'(4'b0100));
            check("rs_data2", 64'(rsp_data), 64'(last_val));
            if (run == 0) words[1] = last_val;
            else check("replay1", 64'(rsp_data), 64'(words[1]));
            req = 4'b0001;
            tick();
            check("rs_gnt3", 64'(gnt), 64'(4'b0001));
            if (run == 0) words[2] = last_val;
            else check("replay2", 64'(rsp_data), 64'(words[2]));
            req = 4'b0000;
            tick();
        end

        // Asynchronous reset mid-grant.
        req = 4'b1111;
        tick();
        check("pre_areset_gnt", 64'(gnt), 64'(4'b0010));
        #2;
        reset = 1'b1;
        #1;
        check("areset_gnt", 64'(gnt), 64'(0));
        check("areset_valid", 64'(rsp_valid), 64'(0));
        check("areset_data", 64'(rsp_data), 64'(0));
        check("areset_draw", 64'(draw_cnt), 64'(0));
        check("areset_ready", 64'(ready), 64'(0));
        check("areset_rng_reset", 64'(rng_reset), 64'(1));
        check("areset_rng_seed", 64'(rng_seed), 64'(0));
        req = 4'b0000;
        tick();
        reset = 1'b0;
        tick();
        check("post_areset_ready", 64'(ready), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
